// File: rtl/reg_share_pkg.sv
// Shared definitions for the register-share arbiter: FSM state encoding
// and the default configuration constants.
package reg_share_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_HOLD  = 2;

    // IDLE: waiting for a request; LOAD: register captures the owner's lane;
    // HOLD: grant persists so the owner can use the register output.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/shared_reg.sv
// Shared WIDTH-bit storage register with load enable and synchronous reset.
module shared_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d on the load strobe; hold the value otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_share_arbiter.sv
// Arbiter granting one requester at a time write access to a shared register.
// The granted lane is loaded one cycle after the grant and the grant is then
// held for HOLD cycles, or released early when the owner drops its request.
// Build option: define REG_SHARE_RR_EN for round-robin selection; without it
// the lowest set request index always wins and no pointer register exists.
//
// Handshake: req is level-sensitive. A requester owns the register while its
// gnt bit is high; q holds its lane from the cycle after gnt rises. Dropping
// req during HOLD ends the grant at the next edge; during LOAD it is ignored.
module reg_share_arbiter
    import reg_share_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int HOLD  = DEF_HOLD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic [WIDTH-1:0]         q
);

    localparam int OW = $clog2(N_REQ);
    localparam int CW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(HOLD - 1);
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    state_t          state, state_d;
    logic [N_REQ-1:0] gnt_d;
    logic [OW-1:0]   owner_d;
    logic            busy_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [OW-1:0]   winner;
    logic            any_req;
    logic            to_idle;
    logic            load;
    logic [WIDTH-1:0] lane;

`ifdef REG_SHARE_RR_EN
    logic [OW-1:0] ptr;
    int            idx;

    // Round-robin pick: first set request scanning upward from ptr, wrapping.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = OW'(idx);
            end
        end
    end

    // Pointer advances past the finishing owner on every return to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (to_idle) begin
            ptr <= (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;
        end
    end
`else
    // Fixed priority pick: lowest set request index wins.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any_req && req[i]) begin
                any_req = 1'b1;
                winner  = OW'(i);
            end
        end
    end
`endif

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_d = state;
        gnt_d   = gnt;
        owner_d = owner;
        busy_d  = busy;
        cnt_d   = cnt;
        to_idle = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    gnt_d   = ONE << winner;
                    owner_d = winner;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = CNT_INIT;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!req[owner] || cnt == '0) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    to_idle = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any in-flight grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            gnt   <= '0;
            owner <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            gnt   <= gnt_d;
            owner <= owner_d;
            busy  <= busy_d;
            cnt   <= cnt_d;
        end
    end

    assign load = (state == S_LOAD);
    assign lane = wdata[int'(owner)*WIDTH +: WIDTH];

    shared_reg #(
        .WIDTH (WIDTH)
    ) u_shared_reg (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .d     (lane),
        .q     (q)
    );

endmodule

// File: doc/reg_share_arbiter.md
# reg_share_arbiter

Arbitrates shared write access to one WIDTH-bit register among N_REQ requesters. One requester is granted at a time. The register loads that requester's data lane and holds the grant for a fixed window, so the owner can use the register output. The block sits between the lab's requester logic (switches, FSMs) and a shared register built from flip-flop cells.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, register/data width
- HOLD, 2, cycles the grant persists after the load cycle (HOLD ≥ 1)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  N_REQ  request lines, level-sensitive, bit i = requester i
- wdata  in  N_REQ*WIDTH  write lanes; lane i = wdata[i*WIDTH +: WIDTH]
- gnt  out  N_REQ  one-hot grant, all-zero when idle
- owner  out  $clog2(N_REQ)  index of current/last grantee
- busy  out  1  high while a grant is active
- q  out  WIDTH  shared register contents

## Operation
- FSM has three states: IDLE, LOAD and HOLD.
- IDLE:
  - If any req bit is set, pick a winner.
  - Register gnt = onehot(winner), owner = winner and busy = 1.
  - Go to LOAD.
  - If no req bit is set, stay in IDLE.
- LOAD:
  - q <= lane[owner].
  - cnt <= HOLD-1.
  - Go to HOLD.
- HOLD, normal exit:
  - If cnt == 0, go to IDLE with gnt = 0 and busy = 0.
  - Otherwise decrement cnt.
- HOLD, early release:
  - If req[owner] = 0, go to IDLE immediately, whatever cnt is.
- req[owner] dropping during LOAD has no effect; the load completes.
- q changes only in LOAD; it retains its value across IDLE.
- On every return to IDLE, the round-robin pointer becomes (owner+1) mod N_REQ.
- Winner selection (round-robin): the first set req bit scanning upward from the pointer, wrapping at N_REQ.
- cnt width: $clog2(HOLD+1).
- Reset behaviour:
  - Reset overrides everything, including mid-LOAD or mid-HOLD.
  - Next edge: state = IDLE, gnt = 0, owner = 0, busy = 0, q = 0, pointer = 0, cnt = 0.

## Timing
- With a request present before edge k, gnt is valid after edge k and q is valid after edge k+1.
- gnt is high for 1+HOLD cycles absent early release.
- There is at least one IDLE cycle between consecutive grants. Back-to-back grants are therefore spaced HOLD+2 cycles.
- All outputs are registered; there is no combinational path from req or wdata to any output.

## Configuration
- REG_SHARE_RR_EN defined: round-robin selection as described.
- REG_SHARE_RR_EN undefined: fixed priority; the lowest set index wins.
  - The pointer register is not built.
  - A continuously requesting req[0] starves all others.

## Structure
- Package reg_share_pkg holds:
  - the state enum typedef (IDLE, LOAD, HOLD)
  - default constants for N_REQ, WIDTH and HOLD
- Sub-module shared_reg holds the storage:
  - WIDTH-bit register with load enable and synchronous reset
  - instantiated once
  - driven by the load strobe (state == LOAD) and the selected lane

## Test plan
All scenarios use N_REQ=4, WIDTH=8, HOLD=2.
- Reset: hold reset 2 cycles with random req/wdata -> gnt=0, owner=0, busy=0, q=0x00.
- Single request: req=0100, lane2=0xA5 before edge 1 -> gnt=0100 and busy=1 after edge 1; q=0xA5 after edge 2; gnt=0 after edge 4.
- All requesting, REG_SHARE_RR_EN defined: req=1111 held, lanes 0x10/0x21/0x32/0x43 -> owner sequence 0,1,2,3,0 and q sequence 0x10,0x21,0x32,0x43,0x10.
- Same stimulus, macro undefined -> owner 0 every grant, q=0x10 every grant.
- Wrap-around: after owner=1 completes (pointer=2), req=1010 -> gnt=1000; next grant with req=1010 -> gnt=0010.
- Early release: owner 1 drops req in the first HOLD cycle -> gnt=0 after the next edge, q retains the loaded value.
- Reset mid-HOLD: assert reset during HOLD -> gnt=0, busy=0, q=0 after that edge.
